rc4_decrypt_loop: RTL and testbench



---
 rtl/rc4_pkg.sv | 28 ++
 rtl/rc4_char_check.sv | 15 +
 rtl/rc4_decrypt_loop.sv | 164 ++++++++++++++++
 tb/tb_rc4_decrypt_loop.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 decrypt datapath and its neighbours.
package rc4_pkg;

    localparam int MSG_LEN_DEFAULT = 32;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_A_LO  = 8'h61;
    localparam logic [7:0] CHAR_Z_LO  = 8'h7A;

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        RD_SI,
        W_SI,
        CAP_SI,
        RD_SJ,
        W_SJ,
        CAP_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        W_F,
        CAP_F,
        WR_DEC,
        DONE
    } dec_state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Flags a byte as plausible plaintext: a space or a lowercase ASCII letter.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       valid
);

    // Pure range test, shared with the key-search controller.
    always_comb begin
        valid = (char_in == CHAR_SPACE) ||
                ((char_in >= CHAR_A_LO) && (char_in <= CHAR_Z_LO));
    end

endmodule

// File: rtl/rc4_decrypt_loop.sv
// RC4 PRGA + XOR decrypt: walks the scheduled S permutation, XORs each
// keystream byte with the encrypted ROM and writes the result to RAM.
module rc4_decrypt_loop
    import rc4_pkg::*;
#(
    parameter int MSG_LEN   = MSG_LEN_DEFAULT,
    parameter int READ_WAIT = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_flag,
    output logic       done_flag,
    output logic       msg_valid,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    input  logic [7:0] s_data_read,
    output logic       s_wren,
    output logic [7:0] rom_address,
    input  logic [7:0] rom_data,
    output logic [7:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wren
);

    localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
    localparam logic [8:0] MSG_LEN_K = 9'(MSG_LEN);

    dec_state_t        state;
    logic [7:0]        i;
    logic [7:0]        j;
    logic [7:0]        si;
    logic [7:0]        sj;
    logic [7:0]        f;
    logic [7:0]        enc;
    logic [8:0]        k;
    logic [WAIT_W-1:0] wait_cnt;
    logic              valid_acc;
    logic [7:0]        dec_byte;
    logic              byte_ok;

    assign dec_byte = f ^ enc;

    rc4_char_check u_char_check (
        .char_in (dec_byte),
        .valid   (byte_ok)
    );

    // Single FSM: sequences reads/swap/keystream fetch per byte, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset || !start_flag) begin
            state       <= IDLE;
            i           <= 8'd0;
            j           <= 8'd0;
            si          <= 8'd0;
            sj          <= 8'd0;
            f           <= 8'd0;
            enc         <= 8'd0;
            k           <= 9'd0;
            wait_cnt    <= '0;
            valid_acc   <= 1'b1;
            s_address   <= 8'd0;
            s_data      <= 8'd0;
            s_wren      <= 1'b0;
            rom_address <= 8'd0;
            dec_address <= 8'd0;
            dec_data    <= 8'd0;
            dec_wren    <= 1'b0;
            done_flag   <= 1'b0;
            msg_valid   <= 1'b0;
        end else begin
            s_wren   <= 1'b0;
            dec_wren <= 1'b0;
            case (state)
                IDLE: begin
                    state <= INC_I;
                end
                INC_I: begin
                    i           <= i + 8'd1;
                    rom_address <= k[7:0];
                    state       <= RD_SI;
                end
                RD_SI: begin
                    s_address <= i;
                    state     <= (READ_WAIT == 0) ? CAP_SI : W_SI;
                end
                W_SI: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= CAP_SI;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CAP_SI: begin
                    si    <= s_data_read;
                    j     <= j + s_data_read;
                    state <= RD_SJ;
                end
                RD_SJ: begin
                    s_address <= j;
                    state     <= (READ_WAIT == 0) ? CAP_SJ : W_SJ;
                end
                W_SJ: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= CAP_SJ;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CAP_SJ: begin
                    sj    <= s_data_read;
                    state <= WR_SI;
                end
                WR_SI: begin
                    s_address <= i;
                    s_data    <= sj;
                    s_wren    <= 1'b1;
                    state     <= WR_SJ;
                end
                WR_SJ: begin
                    s_address <= j;
                    s_data    <= si;
                    s_wren    <= 1'b1;
                    state     <= RD_F;
                end
                RD_F: begin
                    s_address <= si + sj;
                    state     <= (READ_WAIT == 0) ? CAP_F : W_F;
                end
                W_F: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= CAP_F;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CAP_F: begin
                    f     <= s_data_read;
                    enc   <= rom_data;
                    state <= WR_DEC;
                end
                WR_DEC: begin
                    dec_address <= k[7:0];
                    dec_data    <= dec_byte;
                    dec_wren    <= 1'b1;
                    valid_acc   <= valid_acc & byte_ok;
                    k           <= k + 9'd1;
                    state       <= ((k + 9'd1) == MSG_LEN_K) ? DONE : INC_I;
                end
                DONE: begin
                    done_flag <= 1'b1;
                    msg_valid <= valid_acc;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_decrypt_loop.sv
// Bench for rc4_decrypt_loop: a 2-byte instance for hand vectors and wrap
// cases, a 32-byte instance for key-scheduled, random, abort and reset runs.
module tb_rc4_decrypt_loop;
    import rc4_pkg::*;

    localparam int LEN_A = 2;
    localparam int LEN_B = MSG_LEN_DEFAULT;
    localparam int RW    = 2;
    localparam int LAT_A = LEN_A * (10 + 3 * RW) + 1;
    localparam int LAT_B = LEN_B * (10 + 3 * RW) + 1;

    typedef struct {
        logic [7:0] rom0;
        logic [7:0] rom1;
        logic [7:0] dec0;
        logic [7:0] dec1;
        logic       valid;
    } vec_t;

    vec_t vecs [9];

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;

    logic       start_a, done_a, valid_a, s_wren_a, dec_wren_a, load_a;
    logic [7:0] s_address_a, s_data_a, s_rd_a, rom_address_a, rom_rd_a, dec_address_a, dec_data_a;
    logic       start_b, done_b, valid_b, s_wren_b, dec_wren_b, load_b;
    logic [7:0] s_address_b, s_data_b, s_rd_b, rom_address_b, rom_rd_b, dec_address_b, dec_data_b;

    logic [7:0] s_init_a [256], rom_init_a [256], s_mem_a [256], rom_a [256], dec_mem_a [256];
    logic [7:0] s_init_b [256], rom_init_b [256], s_mem_b [256], rom_b [256], dec_mem_b [256];
    logic [255:0] seen_a;
    int dec_writes_a, dec_writes_b, stray_b;

    logic [7:0] base_s [256], exp_s [256], ks [256], pt [256];
    logic       exp_valid;

    always #5 clk = ~clk;

    rc4_decrypt_loop #(.MSG_LEN(LEN_A), .READ_WAIT(RW)) dut_a (
        .clk(clk), .reset(reset), .start_flag(start_a), .done_flag(done_a), .msg_valid(valid_a),
        .s_address(s_address_a), .s_data(s_data_a), .s_data_read(s_rd_a), .s_wren(s_wren_a),
        .rom_address(rom_address_a), .rom_data(rom_rd_a),
        .dec_address(dec_address_a), .dec_data(dec_data_a), .dec_wren(dec_wren_a)
    );

    rc4_decrypt_loop #(.MSG_LEN(LEN_B), .READ_WAIT(RW)) dut_b (
        .clk(clk), .reset(reset), .start_flag(start_b), .done_flag(done_b), .msg_valid(valid_b),
        .s_address(s_address_b), .s_data(s_data_b), .s_data_read(s_rd_b), .s_wren(s_wren_b),
        .rom_address(rom_address_b), .rom_data(rom_rd_b),
        .dec_address(dec_address_b), .dec_data(dec_data_b), .dec_wren(dec_wren_b)
    );

    // Synchronous-read memories for instance A, plus a log of addresses it read.
    always @(posedge clk) begin
        if (load_a) begin
            for (int x = 0; x < 256; x++) begin
                s_mem_a[x]   <= s_init_a[x];
                rom_a[x]     <= rom_init_a[x];
                dec_mem_a[x] <= 8'h00;
            end
            seen_a       <= '0;
            dec_writes_a <= 0;
        end else begin
            if (s_wren_a) s_mem_a[s_address_a] <= s_data_a;
            if (dec_wren_a) begin
                dec_mem_a[dec_address_a] <= dec_data_a;
                dec_writes_a <= dec_writes_a + 1;
            end
            if (!s_wren_a && start_a) seen_a[s_address_a] <= 1'b1;
        end
        s_rd_a   <= s_mem_a[s_address_a];
        rom_rd_a <= rom_a[rom_address_a];
    end

    // Synchronous-read memories for instance B, plus a count of writes made while disabled.
    always @(posedge clk) begin
        if (load_b) begin
            for (int x = 0; x < 256; x++) begin
                s_mem_b[x]   <= s_init_b[x];
                rom_b[x]     <= rom_init_b[x];
                dec_mem_b[x] <= 8'h00;
            end
            dec_writes_b <= 0;
        end else begin
            if (s_wren_b) s_mem_b[s_address_b] <= s_data_b;
            if (dec_wren_b) begin
                dec_mem_b[dec_address_b] <= dec_data_b;
                dec_writes_b <= dec_writes_b + 1;
            end
        end
        if (!start_b && (s_wren_b || dec_wren_b)) stray_b <= stray_b + 1;
        s_rd_b   <= s_mem_b[s_address_b];
        rom_rd_b <= rom_b[rom_address_b];
    end

    function automatic bit isPrintable(input logic [7:0] c);
        return (c == 8'h20) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Key scheduling on plain arrays, producing the permutation handed to the DUT.
    task automatic ksa(input logic [23:0] key);
        int jj = 0;
        logic [7:0] t;
        logic [7:0] kb [3];
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int x = 0; x < 256; x++) base_s[x] = 8'(x);
        for (int x = 0; x < 256; x++) begin
            jj = (jj + base_s[x] + kb[x % 3]) % 256;
            t = base_s[x]; base_s[x] = base_s[jj]; base_s[jj] = t;
        end
    endtask

    task automatic shuffleBase();
        int r;
        logic [7:0] t;
        for (int x = 0; x < 256; x++) base_s[x] = 8'(x);
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = base_s[x]; base_s[x] = base_s[r]; base_s[r] = t;
        end
    endtask

    // RC4 keystream from base_s; leaves ks[] and the final permutation in exp_s[].
    task automatic modelPrga(input int n);
        int ii = 0, jj = 0;
        logic [7:0] t;
        for (int x = 0; x < 256; x++) exp_s[x] = base_s[x];
        for (int kk = 0; kk < n; kk++) begin
            ii = (ii + 1) % 256;
            jj = (jj + exp_s[ii]) % 256;
            t = exp_s[ii]; exp_s[ii] = exp_s[jj]; exp_s[jj] = t;
            ks[kk] = exp_s[(exp_s[ii] + exp_s[jj]) % 256];
        end
    endtask

    task automatic genPlain(input int n, input bit withBad);
        int r;
        logic [7:0] b;
        for (int kk = 0; kk < n; kk++) begin
            r = $urandom_range(26, 0);
            pt[kk] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
        end
        if (withBad) begin
            b = 8'($urandom_range(255, 0));
            while (isPrintable(b)) b = 8'($urandom_range(255, 0));
            pt[$urandom_range(n - 1, 0)] = b;
        end
    endtask

    // Encrypts pt[] under base_s[] into B's ROM image and loads B's memories.
    task automatic prepareB();
        modelPrga(LEN_B);
        exp_valid = 1'b1;
        for (int x = 0; x < 256; x++) begin
            s_init_b[x]   = base_s[x];
            rom_init_b[x] = (x < LEN_B) ? (pt[x] ^ ks[x]) : 8'h00;
        end
        for (int kk = 0; kk < LEN_B; kk++) exp_valid &= isPrintable(pt[kk]);
        @(negedge clk); load_b = 1'b1;
        @(negedge clk); load_b = 1'b0;
    endtask

    task automatic loadA();
        @(negedge clk); load_a = 1'b1;
        @(negedge clk); load_a = 1'b0;
    endtask

    // Counts edges after the one that samples start_flag=1 until done_flag reads 1.
    task automatic waitDone(input bit sel, input int expEdges, input string name);
        int edges = 0;
        bit got = 1'b0;
        @(posedge clk);
        while (!got && edges < 4000) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            got = sel ? done_b : done_a;
        end
        checkOutput({name, " latency"}, 64'(edges), 64'(expEdges));
    endtask

    task automatic checkRunB(input string name);
        int bad = 0;
        for (int kk = 0; kk < LEN_B; kk++)
            checkOutput($sformatf("%s dec[%0d]", name, kk), 64'(dec_mem_b[kk]), 64'(pt[kk]));
        checkOutput({name, " msg_valid"}, 64'(valid_b), 64'(exp_valid));
        checkOutput({name, " dec writes"}, 64'(dec_writes_b), 64'(LEN_B));
        for (int x = 0; x < 256; x++) if (s_mem_b[x] !== exp_s[x]) bad++;
        checkOutput({name, " final S bad entries"}, 64'(bad), 64'd0);
    endtask

    // One table vector on instance A with identity S.
    task automatic applyStimulus(input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        for (int x = 0; x < 256; x++) begin
            s_init_a[x]   = 8'(x);
            rom_init_a[x] = 8'h00;
        end
        rom_init_a[0] = vecs[idx].rom0;
        rom_init_a[1] = vecs[idx].rom1;
        loadA();
        @(negedge clk); start_a = 1'b1;
        waitDone(1'b0, LAT_A, nm);
        checkOutput({nm, " dec[0]"}, 64'(dec_mem_a[0]), 64'(vecs[idx].dec0));
        checkOutput({nm, " dec[1]"}, 64'(dec_mem_a[1]), 64'(vecs[idx].dec1));
        checkOutput({nm, " msg_valid"}, 64'(valid_a), 64'(vecs[idx].valid));
        checkOutput({nm, " dec writes"}, 64'(dec_writes_a), 64'd2);
        checkOutput({nm, " S[1..3]"}, 64'({s_mem_a[1], s_mem_a[2], s_mem_a[3]}), 64'(24'h010302));
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        checkOutput({nm, " flags after drop"}, 64'({done_a, valid_a}), 64'd0);
    endtask

    initial begin
        vecs[0] = '{8'h63, 8'h67, 8'h61, 8'h62, 1'b1};
        vecs[1] = '{8'h02, 8'h67, 8'h00, 8'h62, 1'b0};
        vecs[2] = '{8'h22, 8'h25, 8'h20, 8'h20, 1'b1};
        vecs[3] = '{8'h78, 8'h7F, 8'h7A, 8'h7A, 1'b1};
        vecs[4] = '{8'h61, 8'h67, 8'h63, 8'h62, 1'b1};
        vecs[5] = '{8'h7E, 8'h67, 8'h7C, 8'h62, 1'b0};
        vecs[6] = '{8'h62, 8'h64, 8'h60, 8'h61, 1'b0};
        vecs[7] = '{8'h23, 8'h25, 8'h21, 8'h20, 1'b0};
        vecs[8] = '{8'h79, 8'h67, 8'h7B, 8'h62, 1'b0};

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; load_a = 1'b0; load_b = 1'b0;
        stray_b = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset A outputs", 64'({done_a, valid_a, s_address_a, s_data_a, s_wren_a,
                    rom_address_a, dec_address_a, dec_data_a, dec_wren_a}), 64'd0);
        checkOutput("reset B outputs", 64'({done_b, valid_b, s_address_b, s_data_b, s_wren_b,
                    rom_address_b, dec_address_b, dec_data_b, dec_wren_b}), 64'd0);
        reset = 1'b0;

        for (int v = 0; v < 9; v++) applyStimulus(v);

        // j wraps to 0xFF on byte 0 and back to 0x01 on byte 1; si+sj wraps to 0x00.
        for (int x = 0; x < 256; x++) begin
            s_init_a[x]   = 8'(x);
            rom_init_a[x] = 8'h00;
        end
        s_init_a[1] = 8'hFF; s_init_a[255] = 8'h01;
        rom_init_a[0] = 8'h61; rom_init_a[1] = 8'h60;
        loadA();
        @(negedge clk); start_a = 1'b1;
        waitDone(1'b0, LAT_A, "wrap");
        checkOutput("wrap read of 0xFF", 64'(seen_a[255]), 64'd1);
        checkOutput("wrap dec[0]", 64'(dec_mem_a[0]), 64'h61);
        checkOutput("wrap dec[1]", 64'(dec_mem_a[1]), 64'h63);
        checkOutput("wrap msg_valid", 64'(valid_a), 64'd1);
        checkOutput("wrap S", 64'({s_mem_a[1], s_mem_a[2], s_mem_a[3], s_mem_a[255]}), 64'(32'h020103FF));
        @(negedge clk); start_a = 1'b0;

        // Full chain from the scheduled key 0x000249.
        ksa(24'h000249);
        genPlain(LEN_B, 1'b0);
        prepareB();
        @(negedge clk); start_b = 1'b1;
        waitDone(1'b1, LAT_B, "key249");
        checkRunB("key249");

        // Reset while finished with start held high, then restart on release.
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checkOutput("reset in DONE", 64'({done_b, valid_b}), 64'd0);
        load_b = 1'b1;
        @(negedge clk); load_b = 1'b0; reset = 1'b0;
        waitDone(1'b1, LAT_B, "after reset");
        checkRunB("after reset");
        @(negedge clk); start_b = 1'b0;

        // Random permutations and messages, some carrying one non-letter byte.
        for (int r = 0; r < 3; r++) begin
            shuffleBase();
            genPlain(LEN_B, r[0]);
            prepareB();
            @(negedge clk); start_b = 1'b1;
            waitDone(1'b1, LAT_B, $sformatf("rand%0d", r));
            checkRunB($sformatf("rand%0d", r));
            @(negedge clk); start_b = 1'b0;
        end

        // Abort 40 edges in, hold low 5 cycles while S is restored, then rerun.
        shuffleBase();
        genPlain(LEN_B, 1'b0);
        prepareB();
        @(negedge clk); start_b = 1'b1;
        @(posedge clk);
        repeat (40) @(posedge clk);
        @(negedge clk); start_b = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("abort outputs c%0d", c), 64'({done_b, valid_b, s_address_b, s_data_b,
                        s_wren_b, rom_address_b, dec_address_b, dec_data_b, dec_wren_b}), 64'd0);
            load_b = (c == 0);
        end
        start_b = 1'b1;
        waitDone(1'b1, LAT_B, "restart");
        checkRunB("restart");
        @(negedge clk); start_b = 1'b0;
        @(negedge clk);
        checkOutput("writes while disabled", 64'(stray_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
